// File: rtl/shift_req_pkg.sv
// Shared types and constants for the two-requester shifter scheduler.
// Requester IDs index the per-port vectors: bit 0 is A, bit 1 is B.
package shift_req_pkg;

    localparam int SHIFT_W  = 32;
    localparam int SHIFT_SW = 5;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_id_t;

    typedef struct packed {
        logic [SHIFT_W-1:0]  x;
        logic [SHIFT_SW-1:0] s;
        logic                left;
        logic                logical;
    } shift_op_t;

    function automatic req_id_t other_req(input req_id_t id);
        return (id == REQ_A) ? REQ_B : REQ_A;
    endfunction

endpackage

// File: rtl/shift_rr_arb.sv
// Two-input round-robin arbiter. The priority pointer names the port that
// wins a tie; it moves to the other port after every grant.
module shift_rr_arb
    import shift_req_pkg::*;
(
    input  logic       clk,
    input  logic       srst,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt
);

    req_id_t ptr_q;
    req_id_t ptr_d;

    always_comb begin
        gnt   = 2'b00;
        ptr_d = ptr_q;
        if (en) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = (ptr_q == REQ_A) ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
        if (gnt[0]) begin
            ptr_d = other_req(REQ_A);
        end else if (gnt[1]) begin
            ptr_d = other_req(REQ_B);
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            ptr_q <= REQ_A;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/shift_req_ctrl.sv
// Round-robin two-port scheduler and two-stage (issue, result) pipeline for a
// shared external barrel shifter. Define SHIFT_REQ_STATS_EN for grant counters.
module shift_req_ctrl
    import shift_req_pkg::*;
#(
    parameter int W     = SHIFT_W,
    parameter int SW    = SHIFT_SW,
    parameter int CNT_W = 16
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          REQ_VALID_A,
    input  logic          REQ_VALID_B,
    output logic          REQ_READY_A,
    output logic          REQ_READY_B,
    input  logic [W-1:0]  REQ_X_A,
    input  logic [W-1:0]  REQ_X_B,
    input  logic [SW-1:0] REQ_S_A,
    input  logic [SW-1:0] REQ_S_B,
    input  logic          REQ_LEFT_A,
    input  logic          REQ_LEFT_B,
    input  logic          REQ_LOG_A,
    input  logic          REQ_LOG_B,
    output logic [W-1:0]  SH_X,
    output logic [SW-1:0] SH_S,
    output logic          SH_LEFT,
    output logic          SH_LOG,
    input  logic [W-1:0]  SH_Z,
    output logic          RSP_VALID_A,
    output logic          RSP_VALID_B,
    input  logic          RSP_READY_A,
    input  logic          RSP_READY_B,
`ifdef SHIFT_REQ_STATS_EN
    output logic [CNT_W-1:0] GNT_CNT_A,
    output logic [CNT_W-1:0] GNT_CNT_B,
`endif
    output logic [W-1:0]  RSP_Z
);

    logic [1:0] req_valid;
    logic [1:0] rsp_ready;
    logic [1:0] gnt;
    logic [1:0] req_ready;
    logic [1:0] rsp_valid;
    logic       r_free;
    logic       i_free;

    // Issue stage
    logic          i_valid_q, i_valid_d;
    req_id_t       i_owner_q, i_owner_d;
    logic [W-1:0]  i_x_q, i_x_d;
    logic [SW-1:0] i_s_q, i_s_d;
    logic          i_left_q, i_left_d;
    logic          i_log_q, i_log_d;

    // Result stage
    logic          r_valid_q, r_valid_d;
    req_id_t       r_owner_q, r_owner_d;
    logic [W-1:0]  r_z_q, r_z_d;

    assign req_valid = {REQ_VALID_B, REQ_VALID_A};
    assign rsp_ready = {RSP_READY_B, RSP_READY_A};

    always_comb begin
        r_free = !r_valid_q || rsp_ready[r_owner_q];
        i_free = !i_valid_q || r_free;
    end

    shift_rr_arb u_arb (
        .clk  (CLK),
        .srst (RST),
        .req  (req_valid),
        .en   (i_free),
        .gnt  (gnt)
    );

    always_comb begin
        i_valid_d = i_valid_q;
        i_owner_d = i_owner_q;
        i_x_d     = i_x_q;
        i_s_d     = i_s_q;
        i_left_d  = i_left_q;
        i_log_d   = i_log_q;
        if (i_free) begin
            i_valid_d = |gnt;
            if (gnt[1]) begin
                i_owner_d = REQ_B;
                i_x_d     = REQ_X_B;
                i_s_d     = REQ_S_B;
                i_left_d  = REQ_LEFT_B;
                i_log_d   = REQ_LOG_B;
            end else if (gnt[0]) begin
                i_owner_d = REQ_A;
                i_x_d     = REQ_X_A;
                i_s_d     = REQ_S_A;
                i_left_d  = REQ_LEFT_A;
                i_log_d   = REQ_LOG_A;
            end
        end
    end

    always_comb begin
        r_valid_d = r_valid_q;
        r_owner_d = r_owner_q;
        r_z_d     = r_z_q;
        if (r_free) begin
            r_valid_d = i_valid_q;
            r_owner_d = i_owner_q;
            r_z_d     = SH_Z;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            i_valid_q <= 1'b0;
            r_valid_q <= 1'b0;
        end else begin
            i_valid_q <= i_valid_d;
            r_valid_q <= r_valid_d;
        end
    end

    // Payloads carry no reset; the valid bits alone qualify them.
    always_ff @(posedge CLK) begin
        i_owner_q <= i_owner_d;
        i_x_q     <= i_x_d;
        i_s_q     <= i_s_d;
        i_left_q  <= i_left_d;
        i_log_q   <= i_log_d;
        r_owner_q <= r_owner_d;
        r_z_q     <= r_z_d;
    end

    // Empty stages present zeros so the outputs are defined right after reset.
    assign SH_X    = i_valid_q ? i_x_q : '0;
    assign SH_S    = i_valid_q ? i_s_q : '0;
    assign SH_LEFT = i_valid_q & i_left_q;
    assign SH_LOG  = i_valid_q & i_log_q;
    assign RSP_Z   = r_valid_q ? r_z_q : '0;

    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        assign req_ready[gi] = i_free & gnt[gi];
        assign rsp_valid[gi] = r_valid_q && (r_owner_q == ((gi == 0) ? REQ_A : REQ_B));
    end

    assign REQ_READY_A = req_ready[0];
    assign REQ_READY_B = req_ready[1];
    assign RSP_VALID_A = rsp_valid[0];
    assign RSP_VALID_B = rsp_valid[1];

`ifdef SHIFT_REQ_STATS_EN
    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
        logic [CNT_W-1:0] cnt_q, cnt_d;

        always_comb begin
            cnt_d = cnt_q;
            if (req_ready[gi] && req_valid[gi] && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        always_ff @(posedge CLK) begin
            if (RST) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end
    end

    assign GNT_CNT_A = g_cnt[0].cnt_q;
    assign GNT_CNT_B = g_cnt[1].cnt_q;
`else
    logic [CNT_W-1:0] unused_cnt;
    assign unused_cnt = '0;
`endif

endmodule
